// File: rtl/rp_8bit_ifetch.sv
// Instruction fetch sequencer for rp_8bit: reads program words, assembles 1- or 2-word AVR
// instructions and hands them to the decoder over valid/ready, with redirect and skip support.
module rp_8bit_ifetch #(
  parameter int             PAW     = 16,
  parameter logic [PAW-1:0] RST_VEC = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pmem_req,
  output logic [PAW-1:0] pmem_adr,
  input  logic           pmem_ack,
  input  logic [15:0]    pmem_rdt,
  output logic           ins_vld,
  input  logic           ins_rdy,
  output logic [15:0]    ins_code,
  output logic [15:0]    ins_ext,
  output logic           ins_two,
  output logic [PAW-1:0] ins_pc,
  input  logic           jmp_vld,
  input  logic [PAW-1:0] jmp_adr,
  input  logic           skp_vld
);

  typedef enum logic [1:0] {F1, W1, F2, W2} state_t;

  state_t         state;
  logic [PAW-1:0] pc;
  logic [PAW-1:0] pc_inc;
  logic           skip;
  logic           skip_any;

  // lds/sts (1001_00?x_xxxx_0000) and jmp/call (1001_010x_xxxx_11?x) carry a second word
  function automatic logic is_two_word(input logic [15:0] w);
    return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
           ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
  endfunction

  assign pc_inc   = pc + PAW'(1);
  assign skip_any = skip | skp_vld;
  assign pmem_adr = pc;

  // A new first-word request may go out in the same cycle the held instruction is accepted
  always_comb begin
    pmem_req = 1'b0;
    if (rst && !jmp_vld) begin
      case (state)
        F1:      pmem_req = !ins_vld || ins_rdy;
        F2:      pmem_req = 1'b1;
        default: pmem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= F1;
      pc       <= RST_VEC;
      skip     <= 1'b0;
      ins_vld  <= 1'b0;
      ins_code <= '0;
      ins_ext  <= '0;
      ins_two  <= 1'b0;
      ins_pc   <= '0;
    end else if (jmp_vld) begin
      state   <= F1;
      pc      <= jmp_adr;
      skip    <= 1'b0;
      ins_vld <= 1'b0;
    end else begin
      case (state)
        F1: begin
          if (ins_vld && ins_rdy) ins_vld <= 1'b0;
          // a skip landing on a held, unaccepted instruction drops it right away
          if (skp_vld) begin
            if (ins_vld && !ins_rdy) ins_vld <= 1'b0;
            else                     skip    <= 1'b1;
          end
          if (pmem_req && pmem_ack) state <= W1;
        end
        W1: begin
          ins_code <= pmem_rdt;
          ins_pc   <= pc;
          pc       <= pc_inc;
          if (is_two_word(pmem_rdt)) begin
            ins_two <= 1'b1;
            skip    <= skip_any;
            state   <= F2;
          end else begin
            ins_two <= 1'b0;
            ins_ext <= '0;
            ins_vld <= !skip_any;
            skip    <= 1'b0;
            state   <= F1;
          end
        end
        F2: begin
          if (skp_vld) skip <= 1'b1;
          if (pmem_req && pmem_ack) state <= W2;
        end
        W2: begin
          ins_ext <= pmem_rdt;
          pc      <= pc_inc;
          ins_vld <= !skip_any;
          skip    <= 1'b0;
          state   <= F1;
        end
      endcase
    end
  end

endmodule
